// File: rtl/pulse_gen_single_if.sv
// Command/status bundle between control logic (master) and the pulse transmitter (slave).
interface pulse_gen_single_if #(
    parameter int CNT_W = 22,
    parameter int NUM_W = 16
);
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] high_time;
    logic [CNT_W-1:0] low_time;
    logic [NUM_W-1:0] pulse_num;
    logic             idle_level;
    logic             pulse_out;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [NUM_W-1:0] pulse_cnt;

    modport master (
        output start, stop, high_time, low_time, pulse_num, idle_level,
        input  pulse_out, busy, done, aborted, pulse_cnt
    );

    modport slave (
        input  start, stop, high_time, low_time, pulse_num, idle_level,
        output pulse_out, busy, done, aborted, pulse_cnt
    );
endinterface

// File: rtl/pulse_gen_single.sv
// Single-channel pulse-train transmitter in 50 ns ticks, driven by a start/stop command pair.
// Optional macro PULSE_GEN_CONTINUOUS_EN: a latched pulse_num of 0 runs the train until stop.
module pulse_gen_single #(
    parameter int CNT_W = 22,
    parameter int NUM_W = 16
) (
    input logic               clk,
    input logic               rst_n,
    pulse_gen_single_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW, FIN} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [NUM_W-1:0] NUM_ONE = NUM_W'(1);

    state_t           state;
    logic [CNT_W-1:0] phase_cnt;
    logic [CNT_W-1:0] high_lat;
    logic [CNT_W-1:0] low_lat;
    logic [NUM_W-1:0] num_lat;
    logic             idle_lat;
    logic             pulse_out_r;
    logic             busy_r;
    logic             done_r;
    logic             aborted_r;
    logic [NUM_W-1:0] pulse_cnt_r;

    logic [CNT_W-1:0] high_last;
    logic [CNT_W-1:0] low_last;
    logic             cont_mode;
    logic             num_zero_req;
    logic             train_done;

`ifdef PULSE_GEN_CONTINUOUS_EN
    logic cont_lat;
    assign cont_mode = cont_lat;
`else
    assign cont_mode = 1'b0;
`endif

    // Last phase-counter value of each phase; zero times clamp to a one-cycle phase.
    assign high_last    = (high_lat == '0) ? '0 : high_lat - CNT_ONE;
    assign low_last     = (low_lat == '0) ? '0 : low_lat - CNT_ONE;
    assign num_zero_req = (bus.pulse_num == '0);
    assign train_done   = !cont_mode && (pulse_cnt_r == num_lat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            phase_cnt   <= '0;
            high_lat    <= '0;
            low_lat     <= '0;
            num_lat     <= '0;
            idle_lat    <= 1'b0;
            pulse_out_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            aborted_r   <= 1'b0;
            pulse_cnt_r <= '0;
`ifdef PULSE_GEN_CONTINUOUS_EN
            cont_lat    <= 1'b0;
`endif
        end else begin
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
            case (state)
                IDLE: begin
                    pulse_out_r <= bus.idle_level;
                    if (bus.start && !bus.stop) begin
                        high_lat    <= bus.high_time;
                        low_lat     <= bus.low_time;
                        num_lat     <= bus.pulse_num;
                        idle_lat    <= bus.idle_level;
                        pulse_cnt_r <= '0;
                        phase_cnt   <= '0;
                        busy_r      <= 1'b1;
`ifdef PULSE_GEN_CONTINUOUS_EN
                        cont_lat    <= num_zero_req;
                        state       <= HIGH;
                        pulse_out_r <= ~bus.idle_level;
`else
                        if (num_zero_req) begin
                            state <= FIN;
                        end else begin
                            state       <= HIGH;
                            pulse_out_r <= ~bus.idle_level;
                        end
`endif
                    end
                end
                HIGH: begin
                    if (bus.stop) begin
                        state       <= IDLE;
                        pulse_out_r <= idle_lat;
                        busy_r      <= 1'b0;
                        aborted_r   <= 1'b1;
                        phase_cnt   <= '0;
                    end else if (phase_cnt == high_last) begin
                        state       <= LOW;
                        pulse_out_r <= idle_lat;
                        phase_cnt   <= '0;
                        if (pulse_cnt_r != '1)
                            pulse_cnt_r <= pulse_cnt_r + NUM_ONE;
                    end else begin
                        phase_cnt <= phase_cnt + CNT_ONE;
                    end
                end
                LOW: begin
                    if (bus.stop) begin
                        state       <= IDLE;
                        busy_r      <= 1'b0;
                        aborted_r   <= 1'b1;
                        phase_cnt   <= '0;
                    end else if (phase_cnt == low_last) begin
                        phase_cnt <= '0;
                        if (train_done) begin
                            state  <= FIN;
                            done_r <= 1'b1;
                        end else begin
                            state       <= HIGH;
                            pulse_out_r <= ~idle_lat;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + CNT_ONE;
                    end
                end
                FIN: begin
                    // A zero-length train enters FIN without done, so it spends one extra cycle here.
                    pulse_out_r <= idle_lat;
                    if (done_r) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end else begin
                        done_r <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.pulse_out = pulse_out_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.aborted   = aborted_r;
    assign bus.pulse_cnt = pulse_cnt_r;
endmodule

// File: tb/tb_pulse_gen_single.sv
// Directed bench for pulse_gen_single: hand-computed waveforms sampled on the falling edge.
module tb_pulse_gen_single;
    localparam int CNT_W = 22;
    localparam int NUM_W = 16;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    pulse_gen_single_if #(.CNT_W(CNT_W), .NUM_W(NUM_W)) bus ();

    pulse_gen_single #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    function automatic logic basic_out(int i);
        return (i >= 1 && i <= 4) || (i >= 8 && i <= 11) || (i >= 15 && i <= 18);
    endfunction

    // Presents a command for one cycle; returns 1 ns into cycle T+1.
    task automatic do_start(input int h, input int l, input int n, input logic idle);
        bus.high_time  = CNT_W'(h);
        bus.low_time   = CNT_W'(l);
        bus.pulse_num  = NUM_W'(n);
        bus.idle_level = idle;
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.idle_level = 1'b1;
        repeat (2) @(negedge clk);
        if (bus.pulse_out !== 1'b0) begin n_fail++; $display("FAIL reset pulse_out: got %b want 0", bus.pulse_out); end
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.aborted !== 1'b0) begin
            n_fail++; $display("FAIL reset flags: busy=%b done=%b aborted=%b want 000", bus.busy, bus.done, bus.aborted);
        end
        n_checks++;
        if (bus.pulse_cnt !== '0) begin n_fail++; $display("FAIL reset pulse_cnt: got %0d want 0", bus.pulse_cnt); end
        n_checks++;
        rst_n = 1'b1;
        @(negedge clk);
        if (bus.pulse_out !== 1'b1) begin n_fail++; $display("FAIL idle follow hi: got %b want 1", bus.pulse_out); end
        n_checks++;
        bus.idle_level = 1'b0;
        @(negedge clk);
        if (bus.pulse_out !== 1'b0) begin n_fail++; $display("FAIL idle follow lo: got %b want 0", bus.pulse_out); end
        n_checks++;
    endtask

    task automatic test_basic();
        @(posedge clk); #1;
        do_start(4, 3, 3, 1'b0);
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (bus.pulse_out !== basic_out(i)) begin
                n_fail++; $display("FAIL basic pulse_out cyc T+%0d: got %b want %b", i, bus.pulse_out, basic_out(i));
            end
            n_checks++;
            if (bus.done !== (i == 22)) begin n_fail++; $display("FAIL basic done cyc T+%0d: got %b want %b", i, bus.done, (i == 22)); end
            n_checks++;
            if (bus.busy !== (i <= 22)) begin n_fail++; $display("FAIL basic busy cyc T+%0d: got %b want %b", i, bus.busy, (i <= 22)); end
            n_checks++;
            if (bus.aborted !== 1'b0) begin n_fail++; $display("FAIL basic aborted cyc T+%0d: got %b want 0", i, bus.aborted); end
            n_checks++;
            if (i == 5 && bus.pulse_cnt !== 16'd1) begin n_fail++; $display("FAIL basic pulse_cnt T+5: got %0d want 1", bus.pulse_cnt); end
            if (i == 5) n_checks++;
            if (i >= 22 && bus.pulse_cnt !== 16'd3) begin n_fail++; $display("FAIL basic pulse_cnt T+%0d: got %0d want 3", i, bus.pulse_cnt); end
            if (i >= 22) n_checks++;
        end
    endtask

    task automatic test_ignored();
        @(posedge clk); #1;
        do_start(4, 3, 3, 1'b0);
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (bus.pulse_out !== basic_out(i)) begin
                n_fail++; $display("FAIL ignored pulse_out cyc T+%0d: got %b want %b", i, bus.pulse_out, basic_out(i));
            end
            n_checks++;
            if (bus.done !== (i == 22)) begin n_fail++; $display("FAIL ignored done cyc T+%0d: got %b want %b", i, bus.done, (i == 22)); end
            n_checks++;
            if (i == 5) begin
                bus.high_time = 22'd1; bus.low_time = 22'd7; bus.pulse_num = 16'd9; bus.idle_level = 1'b1;
            end
            if (i == 9) bus.start = 1'b1;
            if (i == 10) bus.start = 1'b0;
            if (i == 12) bus.idle_level = 1'b0;
        end
        if (bus.pulse_cnt !== 16'd3) begin n_fail++; $display("FAIL ignored pulse_cnt: got %0d want 3", bus.pulse_cnt); end
        n_checks++;
        // start together with stop in IDLE must not launch a train
        @(posedge clk); #1;
        bus.stop = 1'b1;
        do_start(4, 3, 3, 1'b0);
        bus.stop = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.pulse_out !== 1'b0) begin
                n_fail++; $display("FAIL start_stop idle cyc T+%0d: busy=%b pulse_out=%b want 0 0", i, bus.busy, bus.pulse_out);
            end
            n_checks++;
        end
    endtask

    task automatic test_zero_clamp();
        bus.idle_level = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_start(0, 0, 2, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            logic eo;
            eo = (i == 1 || i == 3) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (bus.pulse_out !== eo) begin n_fail++; $display("FAIL clamp pulse_out cyc T+%0d: got %b want %b", i, bus.pulse_out, eo); end
            n_checks++;
            if (bus.done !== (i == 5)) begin n_fail++; $display("FAIL clamp done cyc T+%0d: got %b want %b", i, bus.done, (i == 5)); end
            n_checks++;
        end
        if (bus.busy !== 1'b0 || bus.pulse_cnt !== 16'd2) begin
            n_fail++; $display("FAIL clamp end: busy=%b pulse_cnt=%0d want 0 2", bus.busy, bus.pulse_cnt);
        end
        n_checks++;
        bus.idle_level = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_abort();
        logic saw_done;
        saw_done = 1'b0;
        @(posedge clk); #1;
        do_start(10, 10, 5, 1'b0);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
            if (i == 23) begin
                if (bus.pulse_out !== 1'b1) begin n_fail++; $display("FAIL abort pre-stop pulse_out: got %b want 1", bus.pulse_out); end
                n_checks++;
                bus.stop = 1'b1;
            end
            if (i == 24) begin
                bus.stop = 1'b0;
                if (bus.pulse_out !== 1'b0 || bus.busy !== 1'b0 || bus.aborted !== 1'b1) begin
                    n_fail++; $display("FAIL abort response: pulse_out=%b busy=%b aborted=%b want 0 0 1", bus.pulse_out, bus.busy, bus.aborted);
                end
                n_checks++;
                if (bus.pulse_cnt !== 16'd1) begin n_fail++; $display("FAIL abort pulse_cnt: got %0d want 1", bus.pulse_cnt); end
                n_checks++;
            end
            if (i == 25) begin
                if (bus.aborted !== 1'b0) begin n_fail++; $display("FAIL abort strobe width: got %b want 0", bus.aborted); end
                n_checks++;
            end
        end
        if (saw_done !== 1'b0) begin n_fail++; $display("FAIL abort done seen: got %b want 0", saw_done); end
        n_checks++;
    endtask

    task automatic test_pulse_num_zero();
`ifdef PULSE_GEN_CONTINUOUS_EN
        logic saw_done;
        int   exp_cnt;
        saw_done = 1'b0;
        @(posedge clk); #1;
        do_start(2, 3, 0, 1'b0);
        for (int i = 1; i <= 1001; i++) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
            if (i == 996 || i == 997) begin
                if (bus.pulse_out !== 1'b1) begin n_fail++; $display("FAIL cont pulse_out cyc T+%0d: got %b want 1", i, bus.pulse_out); end
                n_checks++;
            end
            if (i == 1000) begin
                exp_cnt = (i - 3) / 5 + 1;
                if (bus.pulse_cnt !== NUM_W'(exp_cnt)) begin n_fail++; $display("FAIL cont pulse_cnt: got %0d want %0d", bus.pulse_cnt, exp_cnt); end
                n_checks++;
                bus.stop = 1'b1;
            end
            if (i == 1001) begin
                bus.stop = 1'b0;
                if (bus.aborted !== 1'b1 || bus.busy !== 1'b0) begin
                    n_fail++; $display("FAIL cont stop: aborted=%b busy=%b want 1 0", bus.aborted, bus.busy);
                end
                n_checks++;
            end
        end
        if (saw_done !== 1'b0) begin n_fail++; $display("FAIL cont done seen: got %b want 0", saw_done); end
        n_checks++;
`else
        @(posedge clk); #1;
        do_start(4, 4, 0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (bus.done !== (i == 2)) begin n_fail++; $display("FAIL zero done cyc T+%0d: got %b want %b", i, bus.done, (i == 2)); end
            n_checks++;
            if (bus.pulse_out !== 1'b0) begin n_fail++; $display("FAIL zero pulse_out cyc T+%0d: got %b want 0", i, bus.pulse_out); end
            n_checks++;
            if (bus.busy !== (i <= 2)) begin n_fail++; $display("FAIL zero busy cyc T+%0d: got %b want %b", i, bus.busy, (i <= 2)); end
            n_checks++;
        end
        if (bus.pulse_cnt !== '0) begin n_fail++; $display("FAIL zero pulse_cnt: got %0d want 0", bus.pulse_cnt); end
        n_checks++;
`endif
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        do_start(10, 2, 2, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        if (bus.pulse_out !== 1'b0 || bus.busy !== 1'b0 || bus.pulse_cnt !== '0) begin
            n_fail++; $display("FAIL async reset: pulse_out=%b busy=%b pulse_cnt=%0d want 0 0 0", bus.pulse_out, bus.busy, bus.pulse_cnt);
        end
        n_checks++;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.aborted !== 1'b0) begin
                n_fail++; $display("FAIL reset strobes: done=%b aborted=%b want 0 0", bus.done, bus.aborted);
            end
            n_checks++;
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_start(1, 1, 1, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (bus.pulse_out !== (i == 1)) begin n_fail++; $display("FAIL post-reset pulse_out cyc T+%0d: got %b want %b", i, bus.pulse_out, (i == 1)); end
            n_checks++;
            if (bus.done !== (i == 3)) begin n_fail++; $display("FAIL post-reset done cyc T+%0d: got %b want %b", i, bus.done, (i == 3)); end
            n_checks++;
        end
        if (bus.pulse_cnt !== 16'd1) begin n_fail++; $display("FAIL post-reset pulse_cnt: got %0d want 1", bus.pulse_cnt); end
        n_checks++;
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.high_time  = '0;
        bus.low_time   = '0;
        bus.pulse_num  = '0;
        bus.idle_level = 1'b0;
        test_reset();
        test_basic();
        test_ignored();
        test_zero_clamp();
        test_abort();
        test_pulse_num_zero();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pulse_gen_single.md
Name: pulse_gen_single

Overview:
- Single-channel pulse transmitter. It drives an output line with a programmed train of pulses of fixed high time and low time.
- It is the sending end of the 20 MHz (50 ns tick) debounced pulse interface. Phase times are programmed in the same 50 ns units as the receiver's filter threshold, so software can set every phase longer than the far-end threshold.
- Controlled by a start/stop command pair. Reports busy, done, aborted and a pulse count back to the control logic.

Parameters:
- CNT_W, 22, width of the phase-time inputs and counter (22 bits covers 200 ms at 50 ns).
- NUM_W, 16, width of the pulse-count request and the progress counter.

Ports:
- clk  input  1  system clock, 20 MHz.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle request to begin a train; accepted only in IDLE.
- stop  input  1  one-cycle abort request.
- high_time  input  CNT_W  active-phase length in clocks; sampled at start.
- low_time  input  CNT_W  inactive-phase length in clocks; sampled at start.
- pulse_num  input  NUM_W  number of pulses to send; sampled at start.
- idle_level  input  1  line level when not in an active phase; sampled at start, live while IDLE.
- pulse_out  output  1  registered line output.
- busy  output  1  high while a train is in progress.
- done  output  1  one-cycle strobe on normal completion.
- aborted  output  1  one-cycle strobe on stop-terminated train.
- pulse_cnt  output  NUM_W  completed pulses in current/last train.

Behaviour:
- Reset values: pulse_out=0, busy=0, done=0, aborted=0, pulse_cnt=0, all internal counters 0, state=IDLE.
- After reset, pulse_out follows idle_level while IDLE, registered (1-cycle lag).
- States: IDLE, HIGH, LOW, FIN.
- IDLE:
  - start=1 and stop=0: latch high_time, low_time, pulse_num and idle_level into shadow registers; clear pulse_cnt; set busy=1.
  - Next state is HIGH, or FIN if latched pulse_num==0.
  - stop=1 in IDLE is ignored, including when start=1 in the same cycle (no train starts).
- Effective phase lengths: Heff = max(high_time,1), Leff = max(low_time,1), computed on the latched values. Zero is never allowed to produce a zero-width phase.
- HIGH:
  - pulse_out = ~idle_lat for exactly Heff cycles. First active cycle is the cycle after start is accepted (latency 1).
  - On the last HIGH cycle, pulse_cnt increments and state goes to LOW.
- LOW:
  - pulse_out = idle_lat for exactly Leff cycles.
  - At the end: if pulse_cnt==pulse_num_lat go to FIN, else go to HIGH.
  - A trailing low phase is always emitted after the final pulse.
- FIN: lasts one cycle. done=1, busy=0 from the next cycle, return to IDLE. pulse_cnt holds its value until the next accepted start.
- Phase counter counts 0..Heff-1 or 0..Leff-1 and clears on every phase change. No wrap is possible, since max Heff/Leff = 2^CNT_W-1 fits.
- pulse_cnt never exceeds pulse_num_lat. The max request 2^NUM_W-1 completes without wrap.
- stop while in HIGH or LOW:
  - Next cycle: state=IDLE, pulse_out=idle_lat, busy=0, aborted=1 for one cycle, done stays 0.
  - pulse_cnt holds completed pulses; a truncated HIGH does not count.
- stop in FIN is ignored: done still fires, aborted does not.
- start while busy is ignored and has no effect on shadow registers. A start in the same cycle as the FIN exit is ignored; start is accepted from IDLE only.
- done and aborted are mutually exclusive, and neither is ever asserted on consecutive cycles.
- rst_n low mid-train: immediate return to reset values; no done or aborted strobe.
- Input changes on high_time, low_time, pulse_num and idle_level during a train have no effect.

Optional Feature:
- Macro: PULSE_GEN_CONTINUOUS_EN.
- Defined: a latched pulse_num==0 means continuous mode.
  - HIGH/LOW alternate indefinitely until stop; done is never asserted.
  - pulse_cnt increments and saturates at 2^NUM_W-1.
  - Stop behaves as above (aborted strobe).
- Not defined: pulse_num==0 goes IDLE -> FIN. done fires 2 cycles after start, with no active phase, pulse_out never leaving idle level, and pulse_cnt=0.

Test Plan:
- Basic train, idle_level=0, high_time=4, low_time=3, pulse_num=3, start at cycle T:
  - pulse_out high T+1..T+4, T+8..T+11 and T+15..T+18; low in the gaps.
  - Trailing low T+19..T+21; done=1 at T+22; busy low from T+23; pulse_cnt=3.
- Zero clamp, high_time=0, low_time=0, pulse_num=2, idle_level=1:
  - pulse_out 0,1,0,1 on T+1..T+4; done at T+5; pulse_cnt=2.
- Abort, high_time=10, low_time=10, pulse_num=5, stop asserted at 3rd cycle of 2nd HIGH:
  - Next cycle pulse_out=0, busy=0, aborted=1, done never asserted; pulse_cnt=1.
- Ignored commands:
  - start during a running train: waveform and latched values unchanged.
  - start+stop together in IDLE: no train, busy stays 0.
  - change high_time mid-train: waveform unchanged.
- pulse_num=0:
  - Macro off: done at T+2, pulse_out static.
  - Macro on: continuous train for 1000 cycles, then stop gives aborted.
- Reset mid-HIGH (rst_n low 2 cycles): all outputs return to reset values asynchronously, no strobes; a new start afterwards produces a normal train.
